// File: rtl/alu_unit.sv
// alu_unit: registered N-bit ALU with N/Z/C/V status flags and one cycle of latency.
module alu_unit #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   Cntr,
   output logic [N-1:0] Result,
   output logic [3:0]   ALUFlags
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLL = 3'b101,
      OP_SRL = 3'b110,
      OP_SRA = 3'b111
   } op_e;

   op_e          op;
   logic [2:0]   shamt;
   logic [N-1:0] b_op;
   logic [N:0]   sum;
   logic [N-1:0] res_c;
   logic         c_c;
   logic         v_c;

   assign op    = op_e'(Cntr);
   assign shamt = B[2:0];

   // Shared adder: SUB reuses the ADD path as A + ~B + 1.
   always_comb begin
      b_op = (op == OP_SUB) ? ~B : B;
      sum  = {1'b0, A} + {1'b0, b_op} + {{N{1'b0}}, (op == OP_SUB)};
   end

   // Operation select; carry and overflow only meaningful for ADD/SUB.
   always_comb begin
      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
      unique case (op)
         OP_ADD, OP_SUB: begin
            res_c = sum[N-1:0];
            c_c   = sum[N];
            // With B already inverted for SUB, one rule covers both cases.
            v_c   = (A[N-1] == b_op[N-1]) && (sum[N-1] != A[N-1]);
         end
         OP_AND: res_c = A & B;
         OP_OR:  res_c = A | B;
         OP_XOR: res_c = A ^ B;
         OP_SLL: res_c = A << shamt;
         OP_SRL: res_c = A >> shamt;
         OP_SRA: res_c = N'($signed(A) >>> shamt);
         default: res_c = '0;
      endcase
   end

   // Output register; reset takes priority and discards the in-flight result.
   always_ff @(posedge clk) begin
      if (rst) begin
         Result   <= '0;
         ALUFlags <= '0;
      end else begin
         Result   <= res_c;
         ALUFlags <= {res_c[N-1], (res_c == '0), c_c, v_c};
      end
   end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit (N=8).
module tb_alu_unit;

   logic       clk;
   logic       rst;
   logic [7:0] A;
   logic [7:0] B;
   logic [2:0] Cntr;
   logic [7:0] Result;
   logic [3:0] ALUFlags;

   int checks;
   int errors;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] res;
      logic [3:0] fl;
   } vec_t;

   alu_unit #(.N(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .Cntr     (Cntr),
      .Result   (Result),
      .ALUFlags (ALUFlags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one operation, let it be captured, and sample 1 time unit after the edge.
   task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      A    = a;
      B    = b;
      Cntr = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(8'd15, 8'd10, 3'b000);
         checks++;
         if (Result !== 8'd0 || ALUFlags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got Result=%0d Flags=%b, want Result=0 Flags=0000", i, Result, ALUFlags);
         end
      end
      // Release: outputs still zero until the next edge captures the operation.
      rst  = 1'b0;
      A    = 8'd15;
      B    = 8'd10;
      Cntr = 3'b000;
      #1;
      checks++;
      if (Result !== 8'd0 || ALUFlags !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release_pre: got Result=%0d Flags=%b, want Result=0 Flags=0000", Result, ALUFlags);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Result !== 8'd25 || ALUFlags !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release_first: got Result=%0d Flags=%b, want Result=25 Flags=0000", Result, ALUFlags);
      end
   endtask

   task automatic test_arith();
      vec_t v[4];
      v[0] = {8'd15,  8'd10,  3'b000, 8'd25, 4'b0000};
      v[1] = {8'd15,  8'd246, 3'b001, 8'd25, 4'b0000};
      v[2] = {8'd255, 8'd255, 3'b001, 8'd0,  4'b0110};
      v[3] = {8'd136, 8'd88,  3'b001, 8'd48, 4'b0011};
      for (int i = 0; i < 4; i++) begin
         step(v[i].a, v[i].b, v[i].op);
         checks++;
         if (Result !== v[i].res || ALUFlags !== v[i].fl) begin
            errors++;
            $display("FAIL arith[%0d]: got Result=%0d Flags=%b, want Result=%0d Flags=%b", i, Result, ALUFlags, v[i].res, v[i].fl);
         end
      end
   endtask

   task automatic test_logic();
      vec_t v[3];
      v[0] = {8'd42, 8'd10,  3'b010, 8'd10,  4'b0000};
      v[1] = {8'd55, 8'd254, 3'b011, 8'd255, 4'b1000};
      v[2] = {8'd20, 8'd128, 3'b100, 8'd148, 4'b1000};
      for (int i = 0; i < 3; i++) begin
         step(v[i].a, v[i].b, v[i].op);
         checks++;
         if (Result !== v[i].res || ALUFlags !== v[i].fl) begin
            errors++;
            $display("FAIL logic[%0d]: got Result=%0d Flags=%b, want Result=%0d Flags=%b", i, Result, ALUFlags, v[i].res, v[i].fl);
         end
      end
   endtask

   task automatic test_shift();
      vec_t v[5];
      v[0] = {8'd37,  8'd154, 3'b101, 8'd148, 4'b1000};
      v[1] = {8'd180, 8'd95,  3'b110, 8'd1,   4'b0000};
      v[2] = {8'd234, 8'd213, 3'b111, 8'd255, 4'b1000};
      // Shift by 0 (upper B bits set) passes A through.
      v[3] = {8'd234, 8'd248, 3'b111, 8'd234, 4'b1000};
      // SLL shifting everything out leaves zero.
      v[4] = {8'd128, 8'd1,   3'b101, 8'd0,   4'b0100};
      for (int i = 0; i < 5; i++) begin
         step(v[i].a, v[i].b, v[i].op);
         checks++;
         if (Result !== v[i].res || ALUFlags !== v[i].fl) begin
            errors++;
            $display("FAIL shift[%0d]: got Result=%0d Flags=%b, want Result=%0d Flags=%b", i, Result, ALUFlags, v[i].res, v[i].fl);
         end
      end
   endtask

   task automatic test_wrap();
      vec_t v[3];
      v[0] = {8'd127, 8'd1, 3'b000, 8'd128, 4'b1001};
      v[1] = {8'd255, 8'd1, 3'b000, 8'd0,   4'b0110};
      v[2] = {8'd0,   8'd0, 3'b001, 8'd0,   4'b0110};
      for (int i = 0; i < 3; i++) begin
         step(v[i].a, v[i].b, v[i].op);
         checks++;
         if (Result !== v[i].res || ALUFlags !== v[i].fl) begin
            errors++;
            $display("FAIL wrap[%0d]: got Result=%0d Flags=%b, want Result=%0d Flags=%b", i, Result, ALUFlags, v[i].res, v[i].fl);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[6];
      v[0] = {8'd1,   8'd2,   3'b000, 8'd3,   4'b0000};
      v[1] = {8'd2,   8'd3,   3'b001, 8'd255, 4'b1000};
      v[2] = {8'd240, 8'd60,  3'b010, 8'd48,  4'b0000};
      v[3] = {8'd128, 8'd128, 3'b000, 8'd0,   4'b0111};
      v[4] = {8'd127, 8'd255, 3'b001, 8'd128, 4'b1001};
      v[5] = {8'd85,  8'd85,  3'b100, 8'd0,   4'b0100};
      for (int i = 0; i < 6; i++) begin
         step(v[i].a, v[i].b, v[i].op);
         checks++;
         if (Result !== v[i].res || ALUFlags !== v[i].fl) begin
            errors++;
            $display("FAIL b2b[%0d]: got Result=%0d Flags=%b, want Result=%0d Flags=%b", i, Result, ALUFlags, v[i].res, v[i].fl);
         end
      end
   endtask

   task automatic test_reset_midstream();
      step(8'd200, 8'd3, 3'b011);
      checks++;
      if (Result !== 8'd203 || ALUFlags !== 4'b1000) begin
         errors++;
         $display("FAIL mid_pre: got Result=%0d Flags=%b, want Result=203 Flags=1000", Result, ALUFlags);
      end
      rst = 1'b1;
      step(8'd15, 8'd10, 3'b000);
      checks++;
      if (Result !== 8'd0 || ALUFlags !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset: got Result=%0d Flags=%b, want Result=0 Flags=0000", Result, ALUFlags);
      end
      rst = 1'b0;
      step(8'd127, 8'd1, 3'b000);
      checks++;
      if (Result !== 8'd128 || ALUFlags !== 4'b1001) begin
         errors++;
         $display("FAIL mid_after: got Result=%0d Flags=%b, want Result=128 Flags=1001", Result, ALUFlags);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      A      = '0;
      B      = '0;
      Cntr   = '0;
      @(negedge clk);
      test_reset();
      test_arith();
      test_logic();
      test_shift();
      test_wrap();
      test_back_to_back();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered N-bit arithmetic/logic unit. Takes two operands and a 3-bit operation code and produces a result plus four status flags: Negative, Zero, Carry, Overflow.
- Sits in the datapath execute stage. Output is registered, with one cycle of latency.
- Feeds condition-flag logic downstream.

Parameters:
- N, 8, operand and result width in bits (N >= 4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A (two's complement or unsigned, per operation).
- B  input  N  operand B; low 3 bits are the shift amount for shift operations.
- Cntr  input  3  operation select.
- Result  output  N  registered operation result.
- ALUFlags  output  4  registered flags: bit3 N, bit2 Z, bit1 C, bit0 V.

Behaviour:
- One clock; reset is synchronous and active-high. On a rising clk edge with rst=1, Result and ALUFlags are set to 0.
  - rst has priority over any operation sampled in the same cycle.
  - A reset mid-stream discards the in-flight result.
- Otherwise, on every rising edge, the outputs capture the combinational result of the current A, B and Cntr.
  - Latency is exactly 1 cycle.
  - Throughput is 1 operation per cycle.
  - There is no handshake.
- Operation encoding of Cntr:
  - 000 ADD: A + B, modulo 2^N.
  - 001 SUB: A - B, computed as A + ~B + 1, modulo 2^N.
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 XOR: A ^ B.
  - 101 SLL: A shifted left logically by B[2:0]; zero fill.
  - 110 SRL: A shifted right logically by B[2:0]; zero fill.
  - 111 SRA: A shifted right arithmetically by B[2:0]; sign fill from A[N-1].
- Shift amount is always B[2:0] (0..7). The upper bits of B are ignored for shifts. A shift by 0 passes A through unchanged.
- Flags:
  - N = Result[N-1], for all operations.
  - Z = 1 when Result == 0, for all operations.
  - C, ADD: carry out of bit N-1 of the (N+1)-bit sum.
  - C, SUB: carry out of A + ~B + 1. C=1 means no borrow (A >= B unsigned); C=0 means borrow.
  - V, ADD: 1 when A and B have the same sign and Result's sign differs.
  - V, SUB: 1 when A and B have different signs and Result's sign differs from A.
  - C = 0 and V = 0 for all logic and shift operations.
- Boundary conditions:
  - Operations wrap modulo 2^N.
  - 255+1 (N=8) gives Result 0, Z=1, C=1, V=0.
  - 127+1 gives Result 128, N=1, V=1, C=0.
  - 0-0 gives Z=1, C=1.
- All Cntr codes are defined; there is no illegal-opcode state.
- Outputs hold their last value only for one cycle; they re-sample every cycle.

Test Plan:
- Reset: assert rst for 2 cycles with nonzero inputs -> Result=0, ALUFlags=0000. Release -> first result appears one edge later.
- Arithmetic (N=8), each checked one cycle after apply:
  - ADD 15+10 -> 25, flags 0000.
  - SUB 15-(-10), B=246 -> 25, flags 0000.
  - SUB 255-255 -> 0, flags 0110.
  - SUB (-120)-88, A=136 -> 48, flags 0011.
- Logic:
  - AND 42&10 -> 10, flags 0000.
  - OR 55|(-2) -> 255, flags 1000.
  - XOR 20^128 -> 148, flags 1000.
- Shifts:
  - SLL A=37, B=154 (amount 2) -> 148, flags 1000.
  - SRL A=180, B=95 (amount 7) -> 1, flags 0000.
  - SRA A=234, B=213 (amount 5) -> 255, flags 1000.
- ADD overflow/wrap:
  - 127+1 -> 128, flags 1001.
  - 255+1 -> 0, flags 0110.
  - Back-to-back ops on consecutive cycles each produce the correct result one cycle later.
- Reset mid-stream: apply ADD 15+10 and assert rst on the same edge -> outputs 0. Next op after release -> its correct result.
